otter_pc_fetch: RTL

- Program-counter register and instruction-fetch sequencer for the Otter core.
- Sits directly downstream of the branch address generator: it consumes the jal, branch and jalr targets, selects the next PC, and drives a request/grant/rvalid handshake to instruction memory.
- The fetched instruction goes to decode through a valid/ready register.

---
 rtl/otter_pc_fetch.sv | 130 +++++++++++++
 1 files changed

// File: rtl/otter_pc_fetch.sv
// Otter program counter and instruction-fetch sequencer (FETCH -> WAIT -> HOLD).
// Define OTTER_PC_MISALIGN_TRAP_EN to trap misaligned taken targets to mtvec instead of masking them.
module otter_pc_fetch #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  pc_sel,
    input  logic [31:0] jal_addr,
    input  logic [31:0] branch_addr,
    input  logic [31:0] jalr_addr,
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ir,
    output logic        ir_valid,
    input  logic        ir_ready,
    output logic        misalign_trap,
    output logic [31:0] misalign_addr
);

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] WORD_MASK = ~XLEN'(3);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t          state, state_nx;
    logic [XLEN-1:0] pc_nx, ir_nx;
    logic            ir_valid_nx;
    logic [XLEN-1:0] target_c, next_pc_c;
    logic            taken_c, trap_c;

    assign pc_plus4  = pc + XLEN'(4);
    assign imem_req  = (state == FETCH);
    assign imem_addr = pc;

    // Next-PC source select; trap vectors are always word-aligned.
    always_comb begin
        target_c = pc_plus4;
        taken_c  = 1'b0;
        case (pc_sel)
            3'd1:    begin target_c = jalr_addr;   taken_c = 1'b1; end
            3'd2:    begin target_c = branch_addr; taken_c = 1'b1; end
            3'd3:    begin target_c = jal_addr;    taken_c = 1'b1; end
            3'd4:    target_c = mtvec & WORD_MASK;
            3'd5:    target_c = mepc & WORD_MASK;
            default: target_c = pc_plus4;
        endcase
    end

`ifdef OTTER_PC_MISALIGN_TRAP_EN
    assign trap_c    = taken_c && (target_c[1:0] != 2'b00);
    assign next_pc_c = trap_c ? (mtvec & WORD_MASK) : target_c;
`else
    assign trap_c    = 1'b0;
    assign next_pc_c = target_c & WORD_MASK;
`endif

    // Next-state and datapath update.
    always_comb begin
        state_nx    = state;
        pc_nx       = pc;
        ir_nx       = ir;
        ir_valid_nx = ir_valid;
        case (state)
            FETCH: begin
                if (imem_gnt) state_nx = WAIT;
            end
            WAIT: begin
                if (imem_rvalid) begin
                    ir_nx       = imem_rdata;
                    ir_valid_nx = 1'b1;
                    state_nx    = HOLD;
                end
            end
            HOLD: begin
                if (ir_ready) begin
                    pc_nx       = next_pc_c;
                    ir_valid_nx = 1'b0;
                    state_nx    = FETCH;
                end
            end
            default: state_nx = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FETCH;
            pc       <= RESET_VEC;
            ir       <= '0;
            ir_valid <= 1'b0;
        end else begin
            state    <= state_nx;
            pc       <= pc_nx;
            ir       <= ir_nx;
            ir_valid <= ir_valid_nx;
        end
    end

`ifdef OTTER_PC_MISALIGN_TRAP_EN
    logic consume_c;
    assign consume_c = (state == HOLD) && ir_ready;

    // Trap pulse lasts one cycle; the offending address is held until the next trap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_trap <= 1'b0;
            misalign_addr <= '0;
        end else begin
            misalign_trap <= consume_c && trap_c;
            if (consume_c && trap_c) misalign_addr <= target_c;
        end
    end
`else
    assign misalign_trap = 1'b0;
    assign misalign_addr = '0;
`endif

endmodule
